ifm_bank_scheduler: RTL and testbench
=====================================

Name: ifm_bank_scheduler

Overview:
- Round-robin scheduler for the ping-pong IFM banks between two conv layers.
- The producer CU writes one full next-layer IFM volume into the bank it is given and pulses `wr_done`.
- The scheduler marks that bank full, hands it to the consumer CU with a `start_to_next` pulse, and frees it when the consumer pulses `rd_done`.
- `mem_empty` feeds back into the producer CU's HOLD logic so the producer never overwrites an unread bank.

Parameters:
- NUMBER_OF_IFM, 2, number of IFM banks (2..4); pointer width is $clog2(NUMBER_OF_IFM), with a minimum of 1.
- STALL_CNT_WIDTH, 16, width of the optional stall counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- wr_done  input  1  one-cycle pulse: producer finished writing bank `wr_bank_sel`
- end_from_next  input  1  level: consumer layer idle and able to accept a start
- rd_done  input  1  one-cycle pulse: consumer finished reading bank `rd_bank_sel`
- wr_bank_sel  output  $clog2(NUMBER_OF_IFM)  bank the producer writes
- rd_bank_sel  output  $clog2(NUMBER_OF_IFM)  bank the consumer reads
- start_to_next  output  1  one-cycle start pulse to the consumer
- mem_empty  output  1  high when at least one bank is free for writing
- bank_full  output  NUMBER_OF_IFM  per-bank full flags
- busy_rd  output  1  high while the consumer owns a bank (C_START or C_BUSY)
- err_overflow  output  1  sticky: `wr_done` arrived with no free bank
- err_underflow  output  1  sticky: `rd_done` arrived outside C_BUSY
- stall_cycles  output  STALL_CNT_WIDTH  optional; see Optional Feature

Behaviour:
- Reset values:
  - all outputs 0, except `mem_empty` = 1
  - wr_ptr = rd_ptr = 0, count = 0, consumer FSM = C_IDLE
- Reset mid-operation: all of the above are forced immediately; a start pulse in flight is dropped.

Pointers and count:
- `wr_bank_sel` = wr_ptr and `rd_bank_sel` = rd_ptr, both registered.
- Pointers increment modulo NUMBER_OF_IFM: NUMBER_OF_IFM-1 wraps to 0.
- count ranges 0..NUMBER_OF_IFM.
- `mem_empty` = (count != NUMBER_OF_IFM), combinational from registered count.

Write accept:
- `wr_done` with count < NUMBER_OF_IFM:
  - bank_full[wr_ptr] <= 1
  - wr_ptr advances
  - count increments
- `wr_done` with count == NUMBER_OF_IFM:
  - ignored; no pointer, count or flag change
  - err_overflow <= 1

Consumer FSM (registered state):
- C_IDLE: if count != 0 and end_from_next, go to C_START.
- C_START:
  - start_to_next = 1 for exactly this one cycle
  - rd_bank_sel is stable
  - unconditionally go to C_BUSY
- C_BUSY: on `rd_done`:
  - bank_full[rd_ptr] <= 0
  - rd_ptr advances
  - count decrements
  - go to C_IDLE

Read errors:
- `rd_done` in C_IDLE or C_START is ignored and sets err_underflow <= 1.

Timing:
- Latency: `wr_done` in cycle N with an empty scheduler and `end_from_next` high gives count = 1 in N+1 and `start_to_next` in N+2.
- Back-to-back reads: `rd_done` in cycle M with another bank full and `end_from_next` high gives the next `start_to_next` in M+2.
- Simultaneous `wr_done` and `rd_done` (C_BUSY, count < NUMBER_OF_IFM):
  - both pointers advance
  - count unchanged
  - bank_full set for the old wr_ptr and cleared for the old rd_ptr
- Simultaneous events with count == NUMBER_OF_IFM: the read frees a bank in the same cycle, so the write is accepted and err_overflow is not set.
- wr_ptr == rd_ptr with count == 0 means empty; with count == NUMBER_OF_IFM it means full.
- `end_from_next` is sampled only in C_IDLE; dropping it while in C_BUSY has no effect.

Optional Feature:
- Macro: IFM_BANK_SCHED_STALL_CNT_EN.
- Defined:
  - stall_cycles increments each cycle that `mem_empty` == 0, saturating at all-ones
  - cleared only by reset
- Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then a single `wr_done` at cycle 10 with `end_from_next` = 1:
  - bank_full = 2'b01 at cycle 11
  - start_to_next pulses at cycle 12 only
  - rd_bank_sel = 0, wr_bank_sel = 1
- Two `wr_done` pulses with `end_from_next` = 0:
  - count = 2, mem_empty = 0, bank_full = 2'b11
  - a third `wr_done` sets err_overflow = 1; pointers are unchanged
- Full banks, then `rd_done` and `wr_done` in the same cycle:
  - bank 0 is freed and rewritten
  - count stays 2, no err_overflow
  - rd_ptr = 1, wr_ptr = 1
- `rd_done` in C_IDLE: err_underflow = 1, count unchanged, no start pulse.
- Wrap-around with NUMBER_OF_IFM = 3:
  - 7 write/read pairs give rd_bank_sel sequence 0,1,2,0,1,2,0
  - exactly 7 start pulses
- Reset asserted in C_BUSY: all outputs return to reset values within the same cycle.
- With the macro defined, hold full for 50 cycles: stall_cycles = 50.

Source files
------------

// File: rtl/ifm_bank_scheduler_if.sv
// Handshake bundle between the producer CU, the consumer CU and the IFM
// bank scheduler. The scheduler connects through the slave modport; the
// CUs (or a test harness) connect through the master modport.
interface ifm_bank_scheduler_if #(
  parameter int NUMBER_OF_IFM   = 2,
  parameter int STALL_CNT_WIDTH = 16
);
  localparam int PTR_W = (NUMBER_OF_IFM > 2) ? $clog2(NUMBER_OF_IFM) : 1;

  logic                       wr_done;
  logic                       end_from_next;
  logic                       rd_done;
  logic [PTR_W-1:0]           wr_bank_sel;
  logic [PTR_W-1:0]           rd_bank_sel;
  logic                       start_to_next;
  logic                       mem_empty;
  logic [NUMBER_OF_IFM-1:0]   bank_full;
  logic                       busy_rd;
  logic                       err_overflow;
  logic                       err_underflow;
  logic [STALL_CNT_WIDTH-1:0] stall_cycles;

  modport slave (
    input  wr_done, end_from_next, rd_done,
    output wr_bank_sel, rd_bank_sel, start_to_next, mem_empty, bank_full,
           busy_rd, err_overflow, err_underflow, stall_cycles
  );

  modport master (
    output wr_done, end_from_next, rd_done,
    input  wr_bank_sel, rd_bank_sel, start_to_next, mem_empty, bank_full,
           busy_rd, err_overflow, err_underflow, stall_cycles
  );
endinterface

// File: rtl/ifm_bank_scheduler.sv
// Round-robin scheduler for the ping-pong IFM banks between two conv layers.
// The producer fills the bank at wr_ptr, the consumer drains the bank at
// rd_ptr; count tracks how many banks hold unread data.
// Optional stall counter: define IFM_BANK_SCHED_STALL_CNT_EN to count the
// cycles during which every bank is full (producer held off).
module ifm_bank_scheduler #(
  parameter int NUMBER_OF_IFM   = 2,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  ifm_bank_scheduler_if.slave    bus
);
  localparam int PTR_W = (NUMBER_OF_IFM > 2) ? $clog2(NUMBER_OF_IFM) : 1;
  localparam int CNT_W = $clog2(NUMBER_OF_IFM + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUMBER_OF_IFM);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUMBER_OF_IFM - 1);

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_START = 2'd1,
    C_BUSY  = 2'd2
  } cons_state_t;

  cons_state_t              state_reg, state_next;
  logic [PTR_W-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]         count_reg, count_next;
  logic [NUMBER_OF_IFM-1:0] bank_full_reg;
  logic                     err_overflow_reg, err_underflow_reg;
  logic                     is_full;
  logic                     rd_accept;
  logic                     wr_accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Accept decisions: a read completing in the same cycle frees a slot,
  // so a write is accepted even when all banks are currently full.
  always_comb begin
    is_full   = (count_reg == FULL_CNT);
    rd_accept = bus.rd_done && (state_reg == C_BUSY);
    wr_accept = bus.wr_done && (!is_full || rd_accept);
  end

  // Consumer FSM next state: start only when data is waiting and the
  // consumer layer reports idle; end_from_next is ignored outside C_IDLE.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      C_IDLE:  if ((count_reg != '0) && bus.end_from_next) state_next = C_START;
      C_START: state_next = C_BUSY;
      C_BUSY:  if (rd_accept) state_next = C_IDLE;
      default: state_next = C_IDLE;
    endcase
  end

  // Pointer and occupancy next values.
  always_comb begin
    wr_ptr_next = wr_accept ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = rd_accept ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next  = count_reg;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // State, pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= C_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Sticky error flags: rejected write, and read completion outside C_BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      if (bus.wr_done && !wr_accept) err_overflow_reg <= 1'b1;
      if (bus.rd_done && !rd_accept) err_underflow_reg <= 1'b1;
    end
  end

  // Per-bank full flags. When the same bank is freed and rewritten in one
  // cycle (full with wr_ptr == rd_ptr) the set wins.
  for (genvar gi = 0; gi < NUMBER_OF_IFM; gi++) begin : g_bank
    // Set on accepted write into this bank, clear on accepted read from it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        bank_full_reg[gi] <= 1'b0;
      end else if (wr_accept && (wr_ptr_reg == PTR_W'(gi))) begin
        bank_full_reg[gi] <= 1'b1;
      end else if (rd_accept && (rd_ptr_reg == PTR_W'(gi))) begin
        bank_full_reg[gi] <= 1'b0;
      end
    end
  end

`ifdef IFM_BANK_SCHED_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_reg;

  // Count cycles with every bank full, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (is_full && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_WIDTH'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt_reg;
`else
  assign bus.stall_cycles = {STALL_CNT_WIDTH{1'b0}};
`endif

  assign bus.wr_bank_sel   = wr_ptr_reg;
  assign bus.rd_bank_sel   = rd_ptr_reg;
  assign bus.start_to_next = (state_reg == C_START);
  assign bus.busy_rd       = (state_reg != C_IDLE);
  assign bus.mem_empty     = !is_full;
  assign bus.bank_full     = bank_full_reg;
  assign bus.err_overflow  = err_overflow_reg;
  assign bus.err_underflow = err_underflow_reg;

endmodule

// File: tb/tb_ifm_bank_scheduler.sv
// Self-checking bench for ifm_bank_scheduler: a directed vector table and
// hand sequences on a 2-bank instance, plus wrap-around and a randomized
// run against a transaction-level model on a 3-bank instance.
// Honours IFM_BANK_SCHED_STALL_CNT_EN for the stall counter expectations.
module tb_ifm_bank_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifm_bank_scheduler_if #(.NUMBER_OF_IFM(2), .STALL_CNT_WIDTH(16)) b2 ();
  ifm_bank_scheduler_if #(.NUMBER_OF_IFM(3), .STALL_CNT_WIDTH(16)) b3 ();

  ifm_bank_scheduler #(.NUMBER_OF_IFM(2), .STALL_CNT_WIDTH(16)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave));
  ifm_bank_scheduler #(.NUMBER_OF_IFM(3), .STALL_CNT_WIDTH(16)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("[TB] ok   %s value=%h", name, act);
    end
  endtask

  // {bank_full, wr_sel, rd_sel, start, mem_empty, busy, ovf, und} of dut2
  function automatic logic [8:0] pack2();
    return {b2.bank_full, b2.wr_bank_sel, b2.rd_bank_sel, b2.start_to_next,
            b2.mem_empty, b2.busy_rd, b2.err_overflow, b2.err_underflow};
  endfunction

  typedef struct {
    logic w, r, e;
    logic [1:0] bf;
    logic ws, rs, st, me, busy, ovf, und;
  } vec_t;

  function automatic vec_t mk(input logic w, r, e, input logic [1:0] bf,
                              input logic ws, rs, st, me, busy, ovf, und);
    vec_t v;
    v.w = w; v.r = r; v.e = e; v.bf = bf; v.ws = ws; v.rs = rs;
    v.st = st; v.me = me; v.busy = busy; v.ovf = ovf; v.und = und;
    return v;
  endfunction

  vec_t tbl [20];

  // start pulse monitor for dut3 (wrap test)
  logic mon_en = 1'b0;
  int   start_cnt = 0;
  always @(negedge clk) if (mon_en && b3.start_to_next) start_cnt++;

  // ---- transaction-level model of a 3-bank scheduler ----
  localparam int N3 = 3;
  int m_wr_total, m_rd_total, m_phase; // phase: 0 idle, 1 start cycle, 2 owned
  logic m_ovf, m_und;
  int m_stall;

  task automatic model_reset();
    m_wr_total = 0; m_rd_total = 0; m_phase = 0;
    m_ovf = 1'b0; m_und = 1'b0; m_stall = 0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic e);
    int cnt;
    logic rd_ok, wr_ok;
    cnt   = m_wr_total - m_rd_total;
    rd_ok = r && (m_phase == 2);
    wr_ok = w && ((cnt < N3) || rd_ok);
    if (w && !wr_ok) m_ovf = 1'b1;
    if (r && !rd_ok) m_und = 1'b1;
    if (cnt == N3 && m_stall < 65535) m_stall++;
    case (m_phase)
      0: if (cnt != 0 && e) m_phase = 1;
      1: m_phase = 2;
      default: if (rd_ok) m_phase = 0;
    endcase
    if (wr_ok) m_wr_total++;
    if (rd_ok) m_rd_total++;
  endtask

  function automatic logic [27:0] model_expect();
    logic [2:0] bf;
    logic [15:0] st;
    int cnt;
    bf = '0;
    for (int k = m_rd_total; k < m_wr_total; k++) bf[k % N3] = 1'b1;
    cnt = m_wr_total - m_rd_total;
`ifdef IFM_BANK_SCHED_STALL_CNT_EN
    st = 16'(m_stall);
`else
    st = 16'd0;
`endif
    return {bf, 2'(m_wr_total % N3), 2'(m_rd_total % N3), (m_phase == 1),
            (cnt != N3), (m_phase != 0), m_ovf, m_und, st};
  endfunction

  function automatic logic [27:0] pack3();
    return {b3.bank_full, b3.wr_bank_sel, b3.rd_bank_sel, b3.start_to_next,
            b3.mem_empty, b3.busy_rd, b3.err_overflow, b3.err_underflow,
            b3.stall_cycles};
  endfunction

  task automatic clear_inputs();
    b2.wr_done = 0; b2.rd_done = 0; b2.end_from_next = 0;
    b3.wr_done = 0; b3.rd_done = 0; b3.end_from_next = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic [1:0] sel;
    logic [15:0] exp_stall;

    // idle, underflow, overflow, simultaneous read/write, wrap of 2-bank ptrs
    tbl[0]  = mk(0,0,1, 2'b00, 0,0,0,1,0,0,0);
    tbl[1]  = mk(1,0,1, 2'b01, 1,0,0,1,0,0,0);
    tbl[2]  = mk(0,0,1, 2'b01, 1,0,1,1,1,0,0);
    tbl[3]  = mk(0,0,1, 2'b01, 1,0,0,1,1,0,0);
    tbl[4]  = mk(0,0,0, 2'b01, 1,0,0,1,1,0,0);
    tbl[5]  = mk(0,1,0, 2'b00, 1,1,0,1,0,0,0);
    tbl[6]  = mk(0,1,0, 2'b00, 1,1,0,1,0,0,1);
    tbl[7]  = mk(1,0,0, 2'b10, 0,1,0,1,0,0,1);
    tbl[8]  = mk(1,0,0, 2'b11, 1,1,0,0,0,0,1);
    tbl[9]  = mk(1,0,0, 2'b11, 1,1,0,0,0,1,1);
    tbl[10] = mk(0,0,1, 2'b11, 1,1,1,0,1,1,1);
    tbl[11] = mk(0,0,1, 2'b11, 1,1,0,0,1,1,1);
    tbl[12] = mk(1,1,1, 2'b11, 0,0,0,0,0,1,1);
    tbl[13] = mk(0,0,1, 2'b11, 0,0,1,0,1,1,1);
    tbl[14] = mk(0,0,0, 2'b11, 0,0,0,0,1,1,1);
    tbl[15] = mk(0,1,0, 2'b10, 0,1,0,1,0,1,1);
    tbl[16] = mk(0,0,1, 2'b10, 0,1,1,1,1,1,1);
    tbl[17] = mk(0,0,1, 2'b10, 0,1,0,1,1,1,1);
    tbl[18] = mk(0,1,1, 2'b00, 0,0,0,1,0,1,1);
    tbl[19] = mk(0,0,1, 2'b00, 0,0,0,1,0,1,1);

    reset = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("reset_state_n2", 64'(pack2()), 64'(9'b00_0_0_0_1_0_0_0));
    check("reset_state_n3", 64'(pack3()), 64'({3'b000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}));
    reset = 1'b0;

    // ---- directed table on the 2-bank instance ----
    for (int i = 0; i < 20; i++) begin
      b2.wr_done = tbl[i].w; b2.rd_done = tbl[i].r; b2.end_from_next = tbl[i].e;
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(pack2()),
            64'({tbl[i].bf, tbl[i].ws, tbl[i].rs, tbl[i].st, tbl[i].me,
                 tbl[i].busy, tbl[i].ovf, tbl[i].und}));
    end
    clear_inputs();

    // ---- asynchronous reset while the consumer owns a bank ----
    b2.wr_done = 1; b2.end_from_next = 1;
    @(negedge clk);
    b2.wr_done = 0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", 64'(b2.busy_rd), 64'd1);
    #2 reset = 1'b1;
    #1 check("async_reset_n2", 64'(pack2()), 64'(9'b00_0_0_0_1_0_0_0));
    check("async_reset_stall", 64'(b2.stall_cycles), 64'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;

    // ---- full for 50 cycles, then simultaneous read/write from full ----
    b2.wr_done = 1;
    @(negedge clk);
    @(negedge clk);
    b2.wr_done = 0;
    check("full_bank_flags", 64'({b2.bank_full, b2.mem_empty, b2.wr_bank_sel}), 64'({2'b11, 1'b0, 1'b0}));
    repeat (50) @(negedge clk);
`ifdef IFM_BANK_SCHED_STALL_CNT_EN
    exp_stall = 16'd50;
`else
    exp_stall = 16'd0;
`endif
    check("stall_after_50", 64'(b2.stall_cycles), 64'(exp_stall));
    b2.end_from_next = 1;
    @(negedge clk);
    check("full_start_bank0", 64'({b2.start_to_next, b2.rd_bank_sel}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    b2.wr_done = 1; b2.rd_done = 1; b2.end_from_next = 0;
    @(negedge clk);
    clear_inputs();
    check("simul_full", 64'({b2.bank_full, b2.mem_empty, b2.wr_bank_sel, b2.rd_bank_sel, b2.err_overflow, b2.busy_rd}),
          64'({2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));

    // ---- wrap-around on the 3-bank instance ----
    do_reset();
    start_cnt = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      b3.wr_done = 1; b3.end_from_next = 1;
      @(negedge clk);
      b3.wr_done = 0;
      found = 1'b0;
      sel = 2'd3;
      for (int k = 0; k < 8 && !found; k++) begin
        @(negedge clk);
        if (b3.start_to_next) begin
          found = 1'b1;
          sel = b3.rd_bank_sel;
        end
      end
      check($sformatf("wrap%0d_start_seen", i), 64'(found), 64'd1);
      check($sformatf("wrap%0d_rd_sel", i), 64'(sel), 64'(i % 3));
      @(negedge clk);
      b3.rd_done = 1;
      @(negedge clk);
      b3.rd_done = 0;
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    clear_inputs();
    check("wrap_start_count", 64'(start_cnt), 64'd7);
    check("wrap_final_ptrs", 64'({b3.wr_bank_sel, b3.rd_bank_sel, b3.err_underflow, b3.err_overflow}),
          64'({2'd1, 2'd1, 1'b0, 1'b0}));

    // ---- randomized run against the transaction model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      logic w, r, e;
      check($sformatf("rand%0d", c), 64'(pack3()), 64'(model_expect()));
      w = ($urandom_range(99) < 35);
      r = ($urandom_range(99) < ((m_phase == 2) ? 40 : 2));
      e = ($urandom_range(99) < 70);
      b3.wr_done = w; b3.rd_done = r; b3.end_from_next = e;
      model_step(w, r, e);
      @(negedge clk);
    end
    check("rand_final", 64'(pack3()), 64'(model_expect()));
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
